// File: rtl/tff_counter.sv
// tff_counter: WIDTH-bit counter/divider primitive built on toggle cells.
//   MODE 00 toggles Q bits selected by T, 01 counts up modulo MOD,
//   10 counts down modulo MOD, 11 loads D (clamped to MOD-1).
//   SATURATE selects hold-at-boundary instead of wrap.
// Ports:
//   CLK      rising-edge clock
//   RST      asynchronous active-high reset (Q = RESET_VAL, OVF = 0)
//   EN       clock enable for Q and OVF updates (CLR_OVF works regardless)
//   MODE     operating mode, see above
//   T        per-bit toggle enables (toggle mode)
//   D        load value (load mode)
//   CLR_OVF  synchronous clear of OVF
//   Q        registered count/state
//   TC       combinational terminal count for the current mode and Q
//   OVF      registered sticky overflow/underflow flag
module tff_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MOD       = 16,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] T,
    input  logic [WIDTH-1:0] D,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);

    // One extra bit so MOD = 2^WIDTH is representable in comparisons.
    localparam int unsigned AW = WIDTH + 1;

    localparam logic [AW-1:0]    MOD_W = AW'(MOD);
    localparam logic [AW-1:0]    TOP_W = AW'(MOD - 1);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
    localparam logic             SAT   = (SATURATE != 0);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_LOAD   = 2'b11
    } mode_e;

    mode_e            mode;
    logic [AW-1:0]    q_w;
    logic [AW-1:0]    d_w;
    logic [WIDTH-1:0] q_next;
    logic             ovf_set;
    logic             ovf_next;

    assign mode = mode_e'(MODE);
    assign q_w  = {1'b0, Q};
    assign d_w  = {1'b0, D};

    // Next-state and overflow-event decode.
    always_comb begin
        q_next  = Q;
        ovf_set = 1'b0;
        if (EN) begin
            case (mode)
                MODE_TOGGLE: begin
                    q_next = Q ^ T;
                end
                MODE_UP: begin
                    // Out-of-range values (left by toggle mode) restart at 0.
                    if (q_w >= MOD_W) begin
                        q_next  = '0;
                        ovf_set = 1'b1;
                    end else if (q_w == TOP_W) begin
                        q_next  = SAT ? Q : '0;
                        ovf_set = 1'b1;
                    end else begin
                        q_next = WIDTH'(q_w + AW'(1));
                    end
                end
                MODE_DOWN: begin
                    // Out-of-range values re-enter at the top without a flag.
                    if (q_w >= MOD_W) begin
                        q_next = TOP;
                    end else if (Q == '0) begin
                        q_next  = SAT ? Q : TOP;
                        ovf_set = 1'b1;
                    end else begin
                        q_next = Q - WIDTH'(1);
                    end
                end
                MODE_LOAD: begin
                    q_next = (d_w < MOD_W) ? D : TOP;
                end
                default: begin
                    q_next = Q;
                end
            endcase
        end
    end

    // A set event in the same cycle as a clear leaves the flag set.
    assign ovf_next = ovf_set | (OVF & ~CLR_OVF);

    // Terminal count for the boundary the current mode is heading to.
    assign TC = EN & (((mode == MODE_UP) & (Q == TOP)) |
                      ((mode == MODE_DOWN) & (Q == '0)));

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q   <= RST_Q;
            OVF <= 1'b0;
        end else begin
            Q   <= q_next;
            OVF <= ovf_next;
        end
    end

endmodule

// File: tb/tb_tff_counter.sv
// Scoreboard bench for tff_counter: two instances (wrap and saturate) share
// stimulus; expected values are queued by the stimulus process and checked
// by an independent monitor process.
module tb_tff_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] t;
    logic [3:0] d;
    logic       clr;

    logic [3:0] q0, q1;
    logic       tc0, tc1, ovf0, ovf1;

    int checks = 0;
    int errors = 0;
    logic done = 1'b0;

    typedef struct {
        logic [1:0] mask;
        logic       tc0;
        logic [3:0] q0;
        logic       o0;
        logic       tc1;
        logic [3:0] q1;
        logic       o1;
    } exp_t;

    exp_t tc_q[$];  // checked just after the negedge (inputs applied, pre-edge)
    exp_t st_q[$];  // checked just after the next posedge
    exp_t im_q[$];  // checked between edges (asynchronous reset)

    tff_counter #(.WIDTH(4), .MOD(10), .SATURATE(0), .RESET_VAL(0)) u_wrap (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .T(t), .D(d),
        .CLR_OVF(clr), .Q(q0), .TC(tc0), .OVF(ovf0)
    );

    tff_counter #(.WIDTH(4), .MOD(10), .SATURATE(1), .RESET_VAL(0)) u_sat (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .T(t), .D(d),
        .CLR_OVF(clr), .Q(q1), .TC(tc1), .OVF(ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations at their sampling points and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (tc_q.size() > 0) begin
                e = tc_q.pop_front();
                if (e.mask[0]) chk("tc_wrap", {3'b0, tc0}, {3'b0, e.tc0});
                if (e.mask[1]) chk("tc_sat",  {3'b0, tc1}, {3'b0, e.tc1});
            end
            #2;
            if (im_q.size() > 0) begin
                e = im_q.pop_front();
                if (e.mask[0]) begin
                    chk("async_q_wrap",   q0, e.q0);
                    chk("async_ovf_wrap", {3'b0, ovf0}, {3'b0, e.o0});
                end
                if (e.mask[1]) begin
                    chk("async_q_sat",   q1, e.q1);
                    chk("async_ovf_sat", {3'b0, ovf1}, {3'b0, e.o1});
                end
            end
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                if (e.mask[0]) begin
                    chk("q_wrap",   q0, e.q0);
                    chk("ovf_wrap", {3'b0, ovf0}, {3'b0, e.o0});
                end
                if (e.mask[1]) begin
                    chk("q_sat",   q1, e.q1);
                    chk("ovf_sat", {3'b0, ovf1}, {3'b0, e.o1});
                end
            end
            if (done) begin
                chk("queues_drained", 4'(tc_q.size() + st_q.size() + im_q.size()), 4'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    // One clock of stimulus: tcX is TC with these inputs before the edge,
    // qX/oX are Q/OVF after the edge.
    task automatic step(input logic [1:0] mask, input logic e_en, input logic [1:0] e_mode,
                        input logic [3:0] e_t, input logic [3:0] e_d, input logic e_clr,
                        input logic x_tc0, input logic [3:0] x_q0, input logic x_o0,
                        input logic x_tc1, input logic [3:0] x_q1, input logic x_o1);
        exp_t e;
        @(negedge clk);
        en   = e_en;
        mode = e_mode;
        t    = e_t;
        d    = e_d;
        clr  = e_clr;
        e.mask = mask;
        e.tc0 = x_tc0; e.q0 = x_q0; e.o0 = x_o0;
        e.tc1 = x_tc1; e.q1 = x_q1; e.o1 = x_o1;
        tc_q.push_back(e);
        st_q.push_back(e);
    endtask

    // Same expectation for both instances.
    task automatic both(input logic e_en, input logic [1:0] e_mode, input logic [3:0] e_t,
                        input logic [3:0] e_d, input logic e_clr,
                        input logic x_tc, input logic [3:0] x_q, input logic x_o);
        step(2'b11, e_en, e_mode, e_t, e_d, e_clr, x_tc, x_q, x_o, x_tc, x_q, x_o);
    endtask

    // Reset asserted between edges; Q/OVF must clear before the next edge.
    task automatic pulse_rst();
        exp_t e;
        @(negedge clk);
        en = 1'b0;
        e.mask = 2'b11;
        e.tc0 = 1'b0; e.q0 = 4'd0; e.o0 = 1'b0;
        e.tc1 = 1'b0; e.q1 = 4'd0; e.o1 = 1'b0;
        im_q.push_back(e);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] up_q0  [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic [3:0] up_q1  [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    logic       up_tc0 [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic       up_tc1 [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic       up_o   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    logic [3:0] dn_q0  [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    logic [3:0] dn_q1  [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic       dn_tc0 [4] = '{0, 0, 1, 0};
    logic       dn_tc1 [4] = '{0, 0, 1, 1};
    logic       dn_o   [4] = '{0, 0, 1, 1};

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        mode = 2'b00;
        t    = 4'd0;
        d    = 4'd0;
        clr  = 1'b0;

        // Reset state.
        both(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset from Q=7, then first count.
        both(1'b1, 2'b11, 4'd0, 4'd7, 1'b0, 1'b0, 4'd7, 1'b0);
        pulse_rst();
        both(1'b1, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0);

        // Up count through the wrap (and the hold for the saturating copy).
        both(1'b1, 2'b11, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 12; i++)
            step(2'b11, 1'b1, 2'b01, 4'd0, 4'd0, 1'b0,
                 up_tc0[i], up_q0[i], up_o[i], up_tc1[i], up_q1[i], up_o[i]);
        // CLR_OVF honoured with EN=0.
        step(2'b11, 1'b0, 2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 4'd9, 1'b0);

        // Down from 2: wrap vs saturate at 0.
        both(1'b1, 2'b11, 4'd0, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++)
            step(2'b11, 1'b1, 2'b10, 4'd0, 4'd0, 1'b0,
                 dn_tc0[i], dn_q0[i], dn_o[i], dn_tc1[i], dn_q1[i], dn_o[i]);

        // Toggle mode, then up from an out-of-range value.
        both(1'b1, 2'b11, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        both(1'b1, 2'b00, 4'b1011, 4'd0, 1'b0, 1'b0, 4'b1011, 1'b0);
        both(1'b1, 2'b00, 4'b1011, 4'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
        both(1'b1, 2'b00, 4'b1111, 4'd0, 1'b0, 1'b0, 4'b1111, 1'b0);
        both(1'b1, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Load clamp and enable gating.
        both(1'b1, 2'b11, 4'd0, 4'd14, 1'b0, 1'b0, 4'd9, 1'b1);
        both(1'b1, 2'b11, 4'd0, 4'd5, 1'b0, 1'b0, 4'd5, 1'b1);
        for (int i = 0; i < 3; i++)
            both(1'b0, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1);

        // Set and clear of OVF in the same cycle.
        both(1'b1, 2'b11, 4'd0, 4'd9, 1'b1, 1'b0, 4'd9, 1'b0);
        step(2'b11, 1'b1, 2'b01, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1);

        // Down from an out-of-range value re-enters at MOD-1 without a flag.
        both(1'b1, 2'b11, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        both(1'b1, 2'b00, 4'b1111, 4'd0, 1'b0, 1'b0, 4'd15, 1'b0);
        both(1'b1, 2'b10, 4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0);

        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        done = 1'b1;
    end

endmodule
